dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
Multi-cycle data-memory responder serving the CPU's MEM-stage load/store requests. It replaces the single-cycle data memory when access latency is non-zero. It holds the word array, serves one request at a time with a programmable latency, and raises stall_o so the pipeline freezes until the access completes. It sits between the EX/MEM pipeline register outputs and the MEM/WB register input.

Parameters:
DEPTH, 32, number of 32-bit words in the array (power of two)
LATENCY, 3, cycles spent in BUSY before completion; legal range 1..15

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset; asynchronous, active-high
req_addr_i  in  32  byte address from EX/MEM ALU result
req_wdata_i  in  32  store data from EX/MEM
req_re_i  in  1  load request (EX/MEM memRead)
req_we_i  in  1  store request (EX/MEM memWrite)
rdata_o  out  32  load data, valid when ack_o=1
ack_o  out  1  one-cycle completion pulse
stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM, MEM/WB while high
err_o  out  1  one-cycle pulse: re and we were both high at request

Behaviour:
- Clock and reset: clk_i is the only clock. rst_i is asynchronous and active-high.
- Reset values: state=IDLE, counter=0, rdata_o=0, ack_o=0, stall_o=0, err_o=0. Array contents are not cleared by reset.
- Addressing:
  - Word index = req_addr_i[log2(DEPTH)+1:2].
  - addr[1:0] is ignored (no misalignment trap).
  - Upper bits are ignored, so addresses wrap modulo DEPTH*4.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If req_re_i|req_we_i, stall_o=1 combinationally in the same cycle.
  - Latch addr, wdata, op; load counter=LATENCY-1; go to BUSY.
  - With no request: stall_o=0, ack_o=0.
- BUSY:
  - stall_o=1.
  - Counter decrements each cycle.
  - At counter==0, the array access happens at that clock edge: the write commits, or the read is captured into rdata_o. Then go to DONE.
- DONE:
  - stall_o=0, ack_o=1, rdata_o holds the read data (a write leaves rdata_o unchanged).
  - The pipeline advances at the end of this cycle. Next state is IDLE.
  - Inputs are not sampled in DONE, so a held request is not re-served.
- Total stall: LATENCY+1 cycles from the request cycle to DONE, then release.
- Both re and we high: treat as a write. err_o pulses in the DONE cycle together with ack_o.
- Request inputs changing during BUSY are ignored; the latched values are used.
- Reset mid-operation: the access is aborted immediately, a pending write never commits, state returns to IDLE.
- rdata_o holds its last value until the next read completes.

Optional Feature:
DMEM_STATS_EN
- Defined: adds output ports rd_cnt_o[31:0], wr_cnt_o[31:0], stall_cnt_o[31:0].
  - rd_cnt_o and wr_cnt_o increment on each completed read or write (in DONE).
  - stall_cnt_o increments on every cycle with stall_o=1.
  - All three reset to 0 and saturate at 32'hFFFFFFFF.
- Not defined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package dmem_pkg:
  - state encoding IDLE=2'd0, BUSY=2'd1, DONE=2'd2
  - WORD_LSB=2
  - max-latency constant 15
  - counter width 4
- Sub-module dmem_array: synchronous single-port word RAM with DEPTH entries, write enable, and registered read. It is instantiated once.
- The FSM, latency counter and statistics logic stay in dmem_responder.

Test Plan:
1. Reset: rst_i high mid-BUSY on a store of 32'hDEADBEEF to 0x10, then release and read 0x10 -> store not committed (old value returned), stall_o=0 immediately on reset assertion.
2. Basic store/load, LATENCY=3: write 32'h12345678 to 0x08, then read 0x08 -> stall_o high 4 cycles per request, ack_o one pulse each, rdata_o=32'h12345678 in the read DONE cycle.
3. Wrap and alignment, DEPTH=32: write 32'hA5A5A5A5 to 0x80, read 0x02 -> rdata_o=32'hA5A5A5A5 (0x80 wraps to word 0, and 0x02 also maps to word 0 since addr[1:0] is ignored).
4. Both re and we high with wdata=32'h0000FFFF at 0x04 -> write commits, err_o and ack_o pulse together, a later read of 0x04 returns 32'h0000FFFF.
5. Inputs toggled during BUSY: request read at 0x0C (preloaded 32'h77), change req_addr_i to 0x10 mid-BUSY -> rdata_o=32'h77.
6. LATENCY=1 with DMEM_STATS_EN defined: two reads and one write back-to-back -> stall_o 2 cycles each, rd_cnt_o=2, wr_cnt_o=1, stall_cnt_o=6.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the multi-cycle data-memory responder.
//   state_t      : responder FSM encoding (IDLE / BUSY / DONE)
//   WORD_LSB     : lowest byte-address bit that selects a word
//   MAX_LATENCY  : largest supported LATENCY value
//   CNT_W        : width of the latency down-counter (holds MAX_LATENCY-1)
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WORD_LSB    = 2;
    localparam int MAX_LATENCY = 15;
    localparam int CNT_W       = 4;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with registered read.
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset; clears only the read register
//   en    : access strobe; with we=1 a write, with we=0 a read
//   we    : write enable (qualified by en)
//   addr  : word index
//   wdata : write data
//   rdata : read register; updated only by a read, holds otherwise
// Array contents are not reset, so the storage maps onto block RAM.
module dmem_array #(
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    // The read register only moves on a read, so a write leaves the last
    // load result visible to the pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage.
// Serves one load/store at a time with LATENCY cycles in BUSY and holds the
// pipeline via stall_o until the access completes.
//   clk_i       : clock, rising edge
//   rst_i       : asynchronous active-high reset
//   req_addr_i  : byte address (word index = addr[log2(DEPTH)+1:2], wraps)
//   req_wdata_i : store data
//   req_re_i    : load request
//   req_we_i    : store request (re and we together = store + err_o)
//   rdata_o     : load data, valid with ack_o, holds until the next load
//   ack_o       : one-cycle completion pulse (DONE state)
//   stall_o     : pipeline freeze, high from the request cycle through BUSY
//   err_o       : one-cycle pulse with ack_o when re and we were both set
// Optional macro DMEM_STATS_EN adds saturating counters rd_cnt_o, wr_cnt_o
// and stall_cnt_o.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 32,
    parameter int LATENCY = 3    // 1..MAX_LATENCY
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic        req_re_i,
    input  logic        req_we_i,
    output logic [31:0] rdata_o,
    output logic        ack_o,
    output logic        stall_o,
    output logic        err_o
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0] rd_cnt_o,
    output logic [31:0] wr_cnt_o,
    output logic [31:0] stall_cnt_o
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(LATENCY - 1);

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [AW-1:0]     addr_reg;
    logic [31:0]       wdata_reg;
    logic              we_reg;
    logic              err_reg;

    logic              req_valid;
    logic              access;
    logic              unused_addr;

    assign req_valid = req_re_i | req_we_i;

    // The array is touched only on the final BUSY edge, so an aborting
    // reset before that edge guarantees a pending store never lands.
    assign access = (state_reg == BUSY) && (cnt_reg == '0);

    // Combinational so the pipeline freezes in the very cycle the request
    // appears; forced low while reset is asserted.
    assign stall_o = !rst_i &&
                     ((state_reg == BUSY) || ((state_reg == IDLE) && req_valid));

    // Byte-offset and upper address bits play no part in word selection.
    assign unused_addr = ^{req_addr_i[31:AW+WORD_LSB], req_addr_i[WORD_LSB-1:0]};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            we_reg    <= 1'b0;
            err_reg   <= 1'b0;
            ack_o     <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            ack_o <= 1'b0;
            err_o <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        addr_reg  <= req_addr_i[AW+WORD_LSB-1:WORD_LSB];
                        wdata_reg <= req_wdata_i;
                        // A simultaneous load+store is carried out as a store.
                        we_reg    <= req_we_i;
                        err_reg   <= req_re_i & req_we_i;
                        cnt_reg   <= LAT_INIT;
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_reg == '0) begin
                        ack_o     <= 1'b1;
                        err_o     <= err_reg;
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                DONE: begin
                    // Inputs are ignored here so a request still held by the
                    // frozen EX/MEM register is not served twice.
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk_i),
        .rst   (rst_i),
        .en    (access),
        .we    (we_reg),
        .addr  (addr_reg),
        .wdata (wdata_reg),
        .rdata (rdata_o)
    );

`ifdef DMEM_STATS_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_cnt_o    <= '0;
            wr_cnt_o    <= '0;
            stall_cnt_o <= '0;
        end else begin
            if ((state_reg == DONE) && !we_reg && (rd_cnt_o != '1)) begin
                rd_cnt_o <= rd_cnt_o + 1'b1;
            end
            if ((state_reg == DONE) && we_reg && (wr_cnt_o != '1)) begin
                wr_cnt_o <= wr_cnt_o + 1'b1;
            end
            if (stall_o && (stall_cnt_o != '1)) begin
                stall_cnt_o <= stall_cnt_o + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: one instance at LATENCY=3 and one
// at LATENCY=1. Expected results come from a per-instance memory model and
// are queued when a request is issued, then popped when ack_o is seen.
module tb_dmem_responder;

    localparam int DEPTH = 32;
    localparam int LAT0  = 3;
    localparam int LAT1  = 1;

    logic        clk = 1'b0;
    logic        rst;

    logic [31:0] req_addr0, req_wdata0, req_addr1, req_wdata1;
    logic        req_re0, req_we0, req_re1, req_we1;
    logic [31:0] rdata0, rdata1;
    logic        ack0, stall0, err0, ack1, stall1, err1;
`ifdef DMEM_STATS_EN
    logic [31:0] rd_cnt0, wr_cnt0, stall_cnt0;
    logic [31:0] rd_cnt1, wr_cnt1, stall_cnt1;
`endif

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] model   [2][DEPTH];
    logic [31:0] last_rd [2];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT0)) dut0 (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_addr_i  (req_addr0),
        .req_wdata_i (req_wdata0),
        .req_re_i    (req_re0),
        .req_we_i    (req_we0),
        .rdata_o     (rdata0),
        .ack_o       (ack0),
        .stall_o     (stall0),
        .err_o       (err0)
`ifdef DMEM_STATS_EN
        ,
        .rd_cnt_o    (rd_cnt0),
        .wr_cnt_o    (wr_cnt0),
        .stall_cnt_o (stall_cnt0)
`endif
    );

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT1)) dut1 (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_addr_i  (req_addr1),
        .req_wdata_i (req_wdata1),
        .req_re_i    (req_re1),
        .req_we_i    (req_we1),
        .rdata_o     (rdata1),
        .ack_o       (ack1),
        .stall_o     (stall1),
        .err_o       (err1)
`ifdef DMEM_STATS_EN
        ,
        .rd_cnt_o    (rd_cnt1),
        .wr_cnt_o    (wr_cnt1),
        .stall_cnt_o (stall_cnt1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input bit re, input bit we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (d == 0) begin
            req_re0 = re; req_we0 = we; req_addr0 = addr; req_wdata0 = wdata;
        end else begin
            req_re1 = re; req_we1 = we; req_addr1 = addr; req_wdata1 = wdata;
        end
    endtask

    function automatic logic get_ack(input int d);
        return (d == 0) ? ack0 : ack1;
    endfunction

    function automatic logic get_stall(input int d);
        return (d == 0) ? stall0 : stall1;
    endfunction

    function automatic logic get_err(input int d);
        return (d == 0) ? err0 : err1;
    endfunction

    function automatic logic [31:0] get_rdata(input int d);
        return (d == 0) ? rdata0 : rdata1;
    endfunction

    // One complete request. With poke set, the address and store data are
    // changed two cycles in to prove the latched values are used.
    task automatic xact(input int d, input bit re, input bit we,
                        input logic [31:0] addr, input logic [31:0] wdata, input bit poke);
        exp_t e;
        int   idx;
        int   lat;
        int   nstall;
        bit   got;
        idx = int'(addr[6:2]);
        lat = (d == 0) ? LAT0 : LAT1;
        if (we) begin
            model[d][idx] = wdata;
            e.data = last_rd[d];
        end else begin
            e.data = model[d][idx];
            last_rd[d] = e.data;
        end
        e.err = re && we;
        sb.push_back(e);

        @(negedge clk);
        drive(d, re, we, addr, wdata);
        #1;
        check("req_cycle_ack", 32'(get_ack(d)), 32'd0);
        nstall = 0;
        got    = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) begin
                @(negedge clk);
                if (poke && c == 2) drive(d, re, we, 32'h10, ~wdata);
                #1;
            end
            if (get_ack(d)) begin
                got = 1'b1;
                break;
            end
            if (get_stall(d)) nstall++;
        end
        drive(d, 1'b0, 1'b0, 32'h0, 32'h0);
        e = sb.pop_front();
        check("ack_seen", 32'(got), 32'd1);
        if (got) begin
            check("stall_cycles", 32'(nstall), 32'(lat + 1));
            check("done_stall", 32'(get_stall(d)), 32'd0);
            check("done_rdata", get_rdata(d), e.data);
            check("done_err", 32'(get_err(d)), 32'(e.err));
        end
        @(negedge clk);
        #1;
        check("ack_one_pulse", 32'(get_ack(d)), 32'd0);
        check("err_one_pulse", 32'(get_err(d)), 32'd0);
        check("idle_stall", 32'(get_stall(d)), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_stall0", 32'(stall0), 32'd0);
        check("rst_ack0",   32'(ack0),   32'd0);
        check("rst_err0",   32'(err0),   32'd0);
        check("rst_rdata0", rdata0,      32'h0);
        check("rst_stall1", 32'(stall1), 32'd0);
        check("rst_rdata1", rdata1,      32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Reset mid-BUSY aborts a store to 0x10
        xact(0, 1'b0, 1'b1, 32'h10, 32'h11111111, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        #1;
        check("abort_req_stall", 32'(stall0), 32'd1);
        @(negedge clk);
        #1;
        check("abort_busy_stall", 32'(stall0), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_rst_stall", 32'(stall0), 32'd0);
        check("abort_rst_ack", 32'(ack0), 32'd0);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_rdata_cleared", rdata0, 32'h0);
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        xact(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);

        // Basic store then load
        xact(0, 1'b0, 1'b1, 32'h08, 32'h12345678, 1'b0);
        xact(0, 1'b1, 1'b0, 32'h08, 32'h0, 1'b0);

        // Address wrap and ignored byte offset
        xact(0, 1'b0, 1'b1, 32'h80, 32'hA5A5A5A5, 1'b0);
        xact(0, 1'b1, 1'b0, 32'h02, 32'h0, 1'b0);

        // re and we together: store plus err pulse
        xact(0, 1'b1, 1'b1, 32'h04, 32'h0000FFFF, 1'b0);
        xact(0, 1'b1, 1'b0, 32'h04, 32'h0, 1'b0);

        // Inputs changed during BUSY are ignored
        xact(0, 1'b0, 1'b1, 32'h0C, 32'h00000077, 1'b0);
        xact(0, 1'b1, 1'b0, 32'h0C, 32'h0, 1'b1);

        // LATENCY=1 instance: one store and two loads back-to-back
        xact(1, 1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 1'b0);
        xact(1, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
        xact(1, 1'b1, 1'b0, 32'hA0, 32'h0, 1'b0);
`ifdef DMEM_STATS_EN
        check("stats_rd_cnt",    rd_cnt1,    32'd2);
        check("stats_wr_cnt",    wr_cnt1,    32'd1);
        check("stats_stall_cnt", stall_cnt1, 32'd6);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
